icache_refill: RTL
==================

# icache_refill

Parametrised direct-mapped instruction cache with multi-word line refill, the next generation of the fetch-stage instruction memory cache. Sits between the IF stage (word-addressed fetch with hit/ready back-pressure) and a backing instruction memory with a request/valid handshake. Adds configurable geometry, a miss-refill state machine, a global flush, and hit/miss performance counters.

## Interface
- `LINES`, 16, number of cache lines; power of 2, ≥2
- `WORDS`, 4, 32-bit words per line; power of 2, ≥1
- `CNT_W`, 16, width of each performance counter
- `clk`  in  1  clock, rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  1  fetch request valid
- `address`  in  32  fetch byte address; bits [1:0] ignored
- `flush`  in  1  invalidate all lines
- `data`  out  32  fetched instruction word
- `hit`  out  1  lookup hit this cycle
- `ready`  out  1  `data` valid for current `address`; stage may advance
- `mem_req`  out  1  backing-memory read request
- `mem_addr`  out  32  word-aligned read address
- `mem_data`  in  32  read data
- `mem_valid`  in  1  `mem_data` valid; completes the outstanding request
- `hit_count`  out  CNT_W  saturating hit counter
- `miss_count`  out  CNT_W  saturating miss counter

## Operation
- Address split: [1:0] byte offset; next log2(WORDS) bits word offset; next log2(LINES) bits index; remaining upper bits tag.
- Storage: per line valid bit, tag, WORDS data words. Only valid bits reset; tag/data arrays not reset.
- FSM states: IDLE, REFILL.
- IDLE: `hit` = `req` & valid[index] & tag match (combinational). `data` = stored word on hit, else 32'h0. `ready` = `hit`.
- IDLE, `req` & !hit: on next edge capture line base (address with word-offset and byte bits zeroed) and tag/index, clear word counter k, go to REFILL, increment `miss_count`.
- REFILL: `mem_req` = 1, `mem_addr` = base + 4*k. One outstanding request; `mem_req`/`mem_addr` held stable until `mem_valid`. On edge with `mem_valid`: write `mem_data` to word k, k++. On the edge accepting word WORDS-1: set valid, write tag, return to IDLE.
- REFILL: `hit` = `ready` = 0, `data` = 0; `address`/`req` changes ignored; refill always completes for captured address.
- `mem_valid` while `mem_req` = 0 is ignored.
- Flush in IDLE: all valid bits cleared on that edge; same-cycle lookup still uses pre-flush state; no miss registered on that edge.
- Flush in REFILL: latched as pending; refill completes, then on the return-to-IDLE edge all valid bits (including the just-filled line) clear.
- `hit_count` increments on each IDLE cycle with `hit` = 1. Both counters saturate at all ones; no wrap.
- Reset (any time, including mid-refill): state IDLE, all valid 0, k 0, pending flush 0, counters 0, `mem_req` 0, `mem_addr` 0, `hit`/`ready` 0, `data` 0. An in-flight memory response after reset is ignored.

## Timing
- Hit latency: 0 cycles (same-cycle combinational lookup).
- Miss, memory answering in the same cycle as `mem_req`: miss in cycle 0; REFILL cycles 1..WORDS; IDLE with hit in cycle WORDS+1. Each memory wait cycle adds one cycle.
- `mem_req` rises on the edge leaving IDLE and falls on the edge accepting the last word; `mem_addr` steps by 4 on each accepting edge.
- Counters are registered and update on the edge following the event.

## Test plan
- Cold miss, LINES=16, WORDS=4, zero-wait memory returning addr^32'hA5A5_0000: fetch 0x40 -> `mem_addr` 0x40,0x44,0x48,0x4C on consecutive cycles; `hit` on cycle 5 with `data`=0xA5A5_0040; `miss_count`=1.
- Sequential fetch 0x40..0x4C after the fill -> 4 consecutive hits, 0 cycles each, `hit_count`=4, no `mem_req`.
- Conflict: fetch 0x40, then 0x440 (same index, different tag), then 0x40 -> three misses; `miss_count`=3; each refill re-reads its line.
- Memory with 2 wait cycles per word -> `mem_addr` held 3 cycles per word; hit on cycle 13; `address` changed mid-refill does not alter the filled line.
- Flush asserted during REFILL of 0x80 -> refill completes, line invalid afterwards; re-fetch of 0x80 misses; flush in IDLE after hits makes all following fetches miss.
- `rst_n` low during REFILL, word 2 -> `mem_req` drops immediately, all outputs 0; after release a fetch of the same address misses and refills from word 0; `hit_count` saturates at 0xFFFF with CNT_W=16.

Source files
------------

// File: rtl/icache_refill.sv
// icache_refill: direct-mapped instruction cache with multi-word line refill.
// Lookup is combinational in IDLE; a miss captures the line base and walks
// the backing memory one word at a time (REFILL) before returning to IDLE.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req, address, flush  fetch request, byte address, invalidate-all
//   data, hit, ready     fetched word, lookup hit, data valid for address
//   mem_req, mem_addr    backing-memory read request and word address
//   mem_data, mem_valid  backing-memory read data and completion
//   hit_count, miss_count saturating performance counters
module icache_refill #(
   parameter int LINES = 16,
   parameter int WORDS = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic [31:0]      address,
   input  logic             flush,
   output logic [31:0]      data,
   output logic             hit,
   output logic             ready,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   input  logic [31:0]      mem_data,
   input  logic             mem_valid,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int FLAT_W = OFF_W + IDX_W;
   localparam int TAG_W  = 30 - FLAT_W;
   localparam int K_W    = (OFF_W > 0) ? OFF_W : 1;
   localparam logic [31:0] LINE_MASK = ~(32'(WORDS) * 32'd4 - 32'd1);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t             state, state_next;
   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tags  [LINES];
   logic [31:0]        words [LINES*WORDS];
   logic [31:0]        base;
   logic [K_W-1:0]     k;
   logic               flush_pend;

   // Lookup fields of the live address; {index, word offset} addresses the
   // flattened word array directly.
   logic [IDX_W-1:0]   idx;
   logic [FLAT_W-1:0]  flat;
   logic [TAG_W-1:0]   tag;
   // Fields of the captured line being refilled.
   logic [IDX_W-1:0]   fill_idx;
   logic [TAG_W-1:0]   fill_tag;
   logic [FLAT_W-1:0]  fill_flat;
   logic               last_word;
   logic               unused_bits;

   assign idx         = address[2+OFF_W +: IDX_W];
   assign flat        = address[2 +: FLAT_W];
   assign tag         = address[31 -: TAG_W];
   assign fill_idx    = base[2+OFF_W +: IDX_W];
   assign fill_tag    = base[31 -: TAG_W];
   assign fill_flat   = base[2 +: FLAT_W] + FLAT_W'(k);
   assign last_word   = (k == K_W'(WORDS - 1));
   assign unused_bits = ^address[1:0];

   always_comb begin
      state_next = state;
      hit        = 1'b0;
      data       = '0;
      ready      = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (state)
         IDLE: begin
            hit   = req && valid[idx] && (tags[idx] == tag);
            data  = hit ? words[flat] : '0;
            ready = hit;
            if (req && !hit && !flush) state_next = REFILL;
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = base + (32'(k) << 2);
            if (mem_valid && last_word) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         valid      <= '0;
         base       <= '0;
         k          <= '0;
         flush_pend <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_next;
         if (hit && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
         case (state)
            IDLE: begin
               // Flush wins over a same-cycle miss: nothing is captured.
               if (flush) begin
                  valid <= '0;
               end else if (req && !hit) begin
                  base <= address & LINE_MASK;
                  k    <= '0;
                  if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
               end
            end
            REFILL: begin
               if (flush) flush_pend <= 1'b1;
               if (mem_valid) begin
                  k <= k + K_W'(1);
                  if (last_word) begin
                     // A flush seen at any point of the refill also drops
                     // the line that was just completed.
                     if (flush || flush_pend) valid <= '0;
                     else valid[fill_idx] <= 1'b1;
                     flush_pend <= 1'b0;
                     k          <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (state == REFILL && mem_valid) begin
         words[fill_flat] <= mem_data;
         if (last_word) tags[fill_idx] <= fill_tag;
      end
   end

endmodule
